// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory-port arbiter.
// Optional round-robin arbitration is enabled by defining IMEM_DMEM_ARBITER_RR_EN.
package imem_dmem_arbiter_pkg;

   localparam int ADDR_W_DFLT = 64;
   localparam int DATA_W_DFLT = 64;
   localparam int INST_W_DFLT = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } gnt_t;

endpackage

// File: rtl/imem_dmem_arbiter_arb_pick.sv
// arb_pick: combinational two-way picker producing a one-hot grant.
// A lone requester always wins; contention goes to LS unless round-robin favours IF.
module imem_dmem_arbiter_arb_pick
   import imem_dmem_arbiter_pkg::*;
(
   input  logic if_valid,
   input  logic ls_valid,
   input  gnt_t last_grant,
   input  logic rr_en,
   output logic gnt_if,
   output logic gnt_ls
);

   always_comb begin
      gnt_if = 1'b0;
      gnt_ls = 1'b0;
      if (if_valid && ls_valid) begin
         if (rr_en && (last_grant == GNT_LS)) begin
            gnt_if = 1'b1;
         end else begin
            gnt_ls = 1'b1;
         end
      end else begin
         gnt_if = if_valid;
         gnt_ls = ls_valid;
      end
   end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define IMEM_DMEM_ARBITER_RR_EN for round-robin arbitration instead of fixed LS priority.
module imem_dmem_arbiter
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int INST_W = INST_W_DFLT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_resp_valid,
   output logic [INST_W-1:0]   if_resp_inst,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_wen,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_wmask,
   output logic                ls_resp_valid,
   output logic [DATA_W-1:0]   ls_resp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_rdata,
   output logic                busy
);

   localparam int MASK_W = DATA_W / 8;

   state_t              state, state_nxt;
   gnt_t                gnt_q;
   gnt_t                last_grant;
   logic                rr_en;
   logic                pick_if, pick_ls;
   logic                accept, capture;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [DATA_W-1:0]   rdata_q;

`ifdef IMEM_DMEM_ARBITER_RR_EN
   assign rr_en = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GNT_IF;
      end else if (accept) begin
         last_grant <= pick_ls ? GNT_LS : GNT_IF;
      end
   end
`else
   assign rr_en      = 1'b0;
   assign last_grant = GNT_IF;
`endif

   imem_dmem_arbiter_arb_pick u_pick (
      .if_valid   (if_req_valid),
      .ls_valid   (ls_req_valid),
      .last_grant (last_grant),
      .rr_en      (rr_en),
      .gnt_if     (pick_if),
      .gnt_ls     (pick_ls)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Readies are only ever raised in IDLE, so nothing is accepted while busy.
   always_comb begin
      state_nxt    = state;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rst && (pick_if || pick_ls)) begin
               if_req_ready = pick_if;
               ls_req_ready = pick_ls;
               accept       = 1'b1;
               state_nxt    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // IF grants carry no write payload, so those fields are latched as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q   <= GNT_IF;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            gnt_q   <= pick_ls ? GNT_LS : GNT_IF;
            addr_q  <= pick_ls ? ls_req_addr : if_req_addr;
            wen_q   <= pick_ls & ls_req_wen;
            wdata_q <= pick_ls ? ls_req_wdata : '0;
            wmask_q <= pick_ls ? ls_req_wmask : '0;
         end
         if (capture) begin
            rdata_q <= ((gnt_q == GNT_LS) && wen_q) ? '0 : mem_resp_rdata;
         end
      end
   end

   assign mem_req_valid = (state == ST_ISSUE);
   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;
   assign busy          = (state != ST_IDLE);

   assign if_resp_valid = (state == ST_RESP) && (gnt_q == GNT_IF);
   assign ls_resp_valid = (state == ST_RESP) && (gnt_q == GNT_LS);
   assign ls_resp_rdata = rdata_q;
   assign if_resp_inst  = addr_q[2] ? rdata_q[2*INST_W-1:INST_W] : rdata_q[INST_W-1:0];

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: directed requests, a small memory model, decoupled monitors.
module tb_imem_dmem_arbiter;

   typedef struct packed {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } memreq_t;

   typedef struct packed {
      logic [63:0] data;
      logic [31:0] cyc;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [63:0] if_req_addr;
   logic [31:0] if_resp_inst;
   logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
   logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_rdata;
   logic [7:0]  ls_req_wmask;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
   logic [7:0]  mem_req_wmask;
   logic        busy;

   int      n_chk = 0;
   int      n_fail = 0;
   int      cyc = 0;
   int      mem_wait = 0;
   int      resp_lat = 0;
   int      stray_cnt = 0;
   logic    busy_log [0:1023];
   memreq_t mq[$];
   resp_t   iq[$];
   resp_t   lq[$];

   imem_dmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_req_addr    (if_req_addr),
      .if_resp_valid  (if_resp_valid),
      .if_resp_inst   (if_resp_inst),
      .ls_req_valid   (ls_req_valid),
      .ls_req_ready   (ls_req_ready),
      .ls_req_addr    (ls_req_addr),
      .ls_req_wen     (ls_req_wen),
      .ls_req_wdata   (ls_req_wdata),
      .ls_req_wmask   (ls_req_wmask),
      .ls_resp_valid  (ls_resp_valid),
      .ls_resp_rdata  (ls_resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .busy           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [63:0] a);
      if (a == 64'h8000_0004) return 64'h1111_2222_3333_4444;
      return {a[31:0] ^ 32'hFFFF_0000, a[31:0] ^ 32'h0000_FFFF};
   endfunction

   // Memory model: ready after mem_wait cycles, response resp_lat cycles after the handshake.
   initial begin
      logic        hs_armed = 1'b0;
      logic        rpend = 1'b0;
      logic [63:0] hs_addr = '0;
      logic [63:0] raddr = '0;
      int          rcnt = 0;
      int          wcnt = 0;
      int          stray_done = 0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_resp_valid = 1'b0;
         mem_resp_rdata = '0;
         if (rst) begin
            hs_armed = 1'b0;
            rpend = 1'b0;
            wcnt = 0;
            mem_req_ready = 1'b0;
            stray_done = stray_cnt;
         end else begin
            if (hs_armed) begin
               rpend = 1'b1;
               rcnt = resp_lat;
               raddr = hs_addr;
            end
            if (rpend) begin
               if (rcnt == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_rdata = mem_data(raddr);
                  rpend = 1'b0;
               end else begin
                  rcnt--;
               end
            end else if (stray_done != stray_cnt) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
               stray_done = stray_cnt;
            end
            if (mem_req_valid) begin
               if (wcnt < mem_wait) begin
                  mem_req_ready = 1'b0;
                  wcnt++;
               end else begin
                  mem_req_ready = 1'b1;
                  wcnt = 0;
               end
            end else begin
               mem_req_ready = 1'b0;
            end
            hs_armed = mem_req_valid && mem_req_ready;
            hs_addr = mem_req_addr;
         end
      end
   end

   // Monitors: memory request fields held and ordered, responses routed, timed and valued.
   initial begin
      memreq_t m;
      resp_t   r;
      forever begin
         @(negedge clk);
         busy_log[cyc % 1024] = busy;
         if (mem_req_valid) begin
            if (mq.size() == 0) begin
               chk("mem_req_unexpected", 192'd1, 192'd0);
            end else begin
               m = mq[0];
               chk("mem_req_fields", {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, m);
               if (mem_req_ready) void'(mq.pop_front());
            end
         end
         if (if_resp_valid) begin
            if (iq.size() == 0) begin
               chk("if_resp_unexpected", 192'd1, 192'd0);
            end else begin
               r = iq.pop_front();
               chk("if_resp_inst", if_resp_inst, r.data);
               chk("if_resp_cycle", cyc, r.cyc);
            end
         end
         if (ls_resp_valid) begin
            if (lq.size() == 0) begin
               chk("ls_resp_unexpected", 192'd1, 192'd0);
            end else begin
               r = lq.pop_front();
               chk("ls_resp_rdata", ls_resp_rdata, r.data);
               chk("ls_resp_cycle", cyc, r.cyc);
            end
         end
      end
   end

   task automatic do_if(input logic [63:0] a, input logic [31:0] exp, input bit push, output int acc);
      bit ok = 1'b0;
      if_req_valid = 1'b1;
      if_req_addr  = a;
      acc = -1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (if_req_ready) begin
            ok = 1'b1;
            acc = cyc;
            mq.push_back('{addr: a, wen: 1'b0, wdata: 64'd0, wmask: 8'd0});
            if (push) iq.push_back('{data: {32'd0, exp}, cyc: 32'(cyc + 3 + mem_wait + resp_lat)});
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("if_req_ready_timeout", 192'd0, 192'd1);
      if_req_valid = 1'b0;
   endtask

   task automatic do_ls(input logic [63:0] a, input logic w, input logic [63:0] wd,
                        input logic [7:0] wm, input logic [63:0] exp, output int acc);
      bit ok = 1'b0;
      ls_req_valid = 1'b1;
      ls_req_addr  = a;
      ls_req_wen   = w;
      ls_req_wdata = wd;
      ls_req_wmask = wm;
      acc = -1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (ls_req_ready) begin
            ok = 1'b1;
            acc = cyc;
            mq.push_back('{addr: a, wen: w, wdata: wd, wmask: wm});
            lq.push_back('{data: exp, cyc: 32'(cyc + 3 + mem_wait + resp_lat)});
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("ls_req_ready_timeout", 192'd0, 192'd1);
      ls_req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy && iq.size() == 0 && lq.size() == 0 && mq.size() == 0) break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, {if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid,
                           mem_req_valid, mem_req_wen, busy}, 192'd0);
      chk({tag, "_resp"}, {if_resp_inst, ls_resp_rdata}, 192'd0);
      chk({tag, "_mreq"}, {mem_req_addr, mem_req_wdata, mem_req_wmask}, 192'd0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int acc_a, acc_b, acc_c;
      int ls_acc[2];
      int if_acc[2];
      int off_if0, off_ls1, off_if1;
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0;
      ls_req_wdata = '0; ls_req_wmask = '0;
      apply_reset();
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;

      // Fetch of the upper word, zero-wait memory
      do_if(64'h8000_0004, 32'h1111_2222, 1'b1, acc_a);
      drain();

      // Contention: LS load wins under fixed priority, IF follows four cycles later
      fork
         do_ls(64'h8000_1000, 1'b0, 64'd0, 8'h00, 64'h7FFF_1000_8000_EFFF, acc_a);
         do_if(64'h8000_0000, 32'h8000_FFFF, 1'b1, acc_b);
      join
      chk("contention_spacing", 192'(acc_b - acc_a), 192'd4);
      drain();

      // Store with memory holding ready low for three cycles
      mem_wait = 3;
      do_ls(64'h8000_3000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F, 64'd0, acc_a);
      drain();
      mem_wait = 0;

      // Stray response in IDLE, then reset while waiting on memory
      stray_cnt++;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("stray_busy", busy, 192'd0);
      @(posedge clk);
      #1;
      resp_lat = 5;
      do_if(64'h8000_0010, 32'd0, 1'b0, acc_a);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("wait_busy", busy, 192'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      repeat (8) @(posedge clk);
      #1;
      resp_lat = 0;
      do_if(64'h8000_0004, 32'h1111_2222, 1'b1, acc_a);
      drain();

      // Back-to-back fetches: accept spacing and single idle cycle
      do_if(64'h8000_0000, 32'h8000_FFFF, 1'b1, acc_a);
      do_if(64'h8000_0004, 32'h1111_2222, 1'b1, acc_b);
      chk("b2b_spacing", 192'(acc_b - acc_a), 192'd4);
      drain();
      acc_c = acc_a;
      chk("b2b_busy", {busy_log[(acc_c + 1) % 1024], busy_log[(acc_c + 2) % 1024],
                       busy_log[(acc_c + 3) % 1024], busy_log[(acc_c + 4) % 1024],
                       busy_log[(acc_c + 5) % 1024]}, 192'b11101);

      // Both requesters held valid across four transactions
      apply_reset();
      @(negedge clk);
      check_reset_outputs("reset2");
      @(posedge clk);
      #1;
      fork
         begin
            for (int k = 0; k < 2; k++)
               do_ls(64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'h7FFF_2000_8000_DFFF, ls_acc[k]);
         end
         begin
            do_if(64'h8000_0008, 32'h8000_FFF7, 1'b1, if_acc[0]);
            do_if(64'h8000_000C, 32'h7FFF_000C, 1'b1, if_acc[1]);
         end
      join
`ifdef IMEM_DMEM_ARBITER_RR_EN
      off_if0 = 4; off_ls1 = 8; off_if1 = 12;
`else
      off_if0 = 8; off_ls1 = 4; off_if1 = 12;
`endif
      chk("arb_if0", 192'(if_acc[0] - ls_acc[0]), 192'(off_if0));
      chk("arb_ls1", 192'(ls_acc[1] - ls_acc[0]), 192'(off_ls1));
      chk("arb_if1", 192'(if_acc[1] - ls_acc[0]), 192'(off_if1));
      drain();

      chk("queues_empty", {32'(mq.size()), 32'(iq.size()), 32'(lq.size())}, 192'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
